// File: rtl/pc_fetch_ctrl.sv
// IF-stage next-PC and fetch sequencer: owns the PC, runs the imem request handshake, feeds IF/ID.
// Optional build macro BRANCH_DELAY_SLOT_EN keeps the slot instruction alive across a redirect.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        id_valid_i,
   input  logic [1:0]  id_pc_sel_i,
   input  logic        id_br_taken_i,
   input  logic [31:0] id_pc_i,
   input  logic [15:0] id_imm16_i,
   input  logic [25:0] id_jidx_i,
   input  logic [31:0] id_rs_data_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        if_valid_o,
   output logic        flush_ifid_o,
   output logic [31:0] link_pc_o
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DelaySlot = 1'b1;
`else
   localparam bit DelaySlot = 1'b0;
`endif

   typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] skid_q, skid_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;

   logic [31:0] id_pc_p4, br_off, br_tgt, jr_tgt, j_tgt, tgt;
   logic [31:0] pc_p4, next_seq_pc;
   logic        redir_sel, redirect, fetch_ack;
   logic        unused_rs;

   assign id_pc_p4 = id_pc_i + 32'd4;
   assign br_off   = {{14{id_imm16_i[15]}}, id_imm16_i, 2'b00};
   assign br_tgt   = id_pc_p4 + br_off;
   assign jr_tgt   = {id_rs_data_i[31:2], 2'b00};
   assign j_tgt    = {id_pc_p4[31:28], id_jidx_i, 2'b00};
   assign unused_rs = ^id_rs_data_i[1:0];

   always_comb begin
      tgt = id_pc_p4;
      unique case (id_pc_sel_i)
         2'b01:   tgt = br_tgt;
         2'b10:   tgt = jr_tgt;
         2'b11:   tgt = j_tgt;
         default: tgt = id_pc_p4;
      endcase
   end

   assign redir_sel = (id_pc_sel_i == 2'b11) || (id_pc_sel_i == 2'b10) ||
                      ((id_pc_sel_i == 2'b01) && id_br_taken_i);
   assign redirect  = id_valid_i && !stall_i && redir_sel;
   assign fetch_ack = (state_q == StFetch) && imem_ack_i;
   assign pc_p4     = pc_q + 32'd4;
   // A deferred delay-slot redirect takes over from the sequential increment.
   assign next_seq_pc = pend_valid_q ? pend_pc_q : pc_p4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      if_valid_d   = if_valid_q;
      skid_d       = skid_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;

      if (redirect && !DelaySlot) begin
         pc_d       = tgt;
         if_valid_d = 1'b0;
         // A request still waiting for its ack must be drained before refetching.
         state_d    = ((state_q != StHold) && !imem_ack_i) ? StDrop : StFetch;
      end else if (stall_i) begin
         if (fetch_ack) begin
            skid_d  = imem_rdata_i;
            state_d = StHold;
         end else if ((state_q == StDrop) && imem_ack_i) begin
            state_d = StFetch;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ack_i) begin
                  if_instr_d   = imem_rdata_i;
                  if_pc_d      = pc_q;
                  if_valid_d   = 1'b1;
                  pc_d         = next_seq_pc;
                  pend_valid_d = 1'b0;
               end else begin
                  if_valid_d = 1'b0;
               end
            end
            StHold: begin
               if_instr_d   = skid_q;
               if_pc_d      = pc_q;
               if_valid_d   = 1'b1;
               pc_d         = next_seq_pc;
               pend_valid_d = 1'b0;
               state_d      = StFetch;
            end
            StDrop: begin
               if_valid_d = 1'b0;
               if (imem_ack_i) state_d = StFetch;
            end
            default: state_d = StFetch;
         endcase

         if (redirect) begin
            // Delay-slot build: slot fetch still in flight, so park the target.
            if ((state_q == StFetch) && !imem_ack_i) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = tgt;
            end else begin
               pc_d         = tgt;
               pend_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         if_instr_q   <= 32'h0;
         if_pc_q      <= 32'h0;
         if_valid_q   <= 1'b0;
         skid_q       <= 32'h0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         if_valid_q   <= if_valid_d;
         skid_q       <= skid_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign imem_req_o   = (state_q == StFetch);
   assign imem_addr_o  = pc_q;
   assign if_instr_o   = if_instr_q;
   assign if_pc_o      = if_pc_q;
   assign if_valid_o   = if_valid_q;
   assign flush_ifid_o = redirect && !DelaySlot && !rst_i;
   assign link_pc_o    = id_pc_i + (DelaySlot ? 32'd8 : 32'd4);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed stimulus queues expected fetch addresses and
// IF/ID deliveries; independent monitors pop and compare at the falling edge.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, stall, id_valid, id_br_taken, imem_ack;
   logic [1:0]  id_pc_sel;
   logic [31:0] id_pc, id_rs_data, imem_rdata;
   logic [15:0] id_imm16;
   logic [25:0] id_jidx;
   logic        imem_req, if_valid, flush_ifid;
   logic [31:0] imem_addr, if_instr, if_pc, link_pc;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_fetch[$];
   logic [31:0] exp_if[$];

   localparam logic [31:0] InstrKey = 32'hDEAD_0000;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ InstrKey;

   pc_fetch_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .id_valid_i    (id_valid),
      .id_pc_sel_i   (id_pc_sel),
      .id_br_taken_i (id_br_taken),
      .id_pc_i       (id_pc),
      .id_imm16_i    (id_imm16),
      .id_jidx_i     (id_jidx),
      .id_rs_data_i  (id_rs_data),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .if_instr_o    (if_instr),
      .if_pc_o       (if_pc),
      .if_valid_o    (if_valid),
      .flush_ifid_o  (flush_ifid),
      .link_pc_o     (link_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [1:0] sel, input logic tk,
                         input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] rs);
      id_valid = v; id_pc_sel = sel; id_br_taken = tk;
      id_pc = pc; id_imm16 = imm; id_jidx = jidx; id_rs_data = rs;
   endtask

   // Fetch monitor: every accepted request must match the next expected address.
   always @(negedge clk) begin
      if (!rst && imem_req && imem_ack) begin
         if (exp_fetch.size() == 0) begin
            checks++; errors++;
            $display("FAIL fetch_extra: got %h expected none at %0t", imem_addr, $time);
         end else begin
            chk("fetch_addr", imem_addr, exp_fetch.pop_front());
         end
      end
   end

   // IF/ID monitor: an instruction is consumed when live, not stalled and not flushed.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && if_valid && !stall && !flush_ifid) begin
         if (exp_if.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_extra: got %h expected none at %0t", if_pc, $time);
         end else begin
            e = exp_if.pop_front();
            chk("if_pc", if_pc, e);
            chk("if_instr", if_instr, e ^ InstrKey);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; imem_ack = 1'b1;
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_flush", {31'h0, flush_ifid}, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h1);
      chk("rst_addr", imem_addr, 32'h0000_3000);

      // Sequential fetch, ack every cycle.
      rst = 1'b0;
      exp_fetch.push_back(32'h3000); exp_fetch.push_back(32'h3004);
      exp_fetch.push_back(32'h3008);
      exp_if.push_back(32'h3000); exp_if.push_back(32'h3004); exp_if.push_back(32'h3008);
      tick(); tick(); tick();
      imem_ack = 1'b0;
      tick();

      // Taken beq at 0x3010, offset -4 words -> 0x3004.
      imem_ack = 1'b1;
      set_id(1'b1, 2'b01, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'h0);
      exp_fetch.push_back(32'h300C);
      #3 chk("beq_flush", {31'h0, flush_ifid}, 32'h1);
      tick();
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      exp_fetch.push_back(32'h3004);
      #3 chk("beq_flush_1cyc", {31'h0, flush_ifid}, 32'h0);
      chk("beq_target", imem_addr, 32'h3004);
      tick();

      // jal at 0x3020 -> 0x3040.
      set_id(1'b1, 2'b11, 1'b0, 32'h3020, 16'h0, 26'h000_0C10, 32'h0);
      exp_fetch.push_back(32'h3008);
      #3 chk("jal_flush", {31'h0, flush_ifid}, 32'h1);
`ifdef BRANCH_DELAY_SLOT_EN
      chk("jal_link", link_pc, 32'h3028);
`else
      chk("jal_link", link_pc, 32'h3024);
`endif
      tick();
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      exp_fetch.push_back(32'h3040);
      exp_if.push_back(32'h3040); exp_if.push_back(32'h3044);
      #3 chk("jal_target", imem_addr, 32'h3040);
      tick();

      // Stall 3 cycles, ack in the first one: skid then deliver.
      stall = 1'b1;
      exp_fetch.push_back(32'h3044);
      tick();
      imem_ack = 1'b0;
      #3 chk("hold_req_a", {31'h0, imem_req}, 32'h0);
      tick();
      #3 chk("hold_req_b", {31'h0, imem_req}, 32'h0);
      tick();
      stall = 1'b0;
      tick();
      imem_ack = 1'b1;
      exp_fetch.push_back(32'h3048);
      tick();

      // jr to 0x4000 with the 0x304C fetch outstanding; its ack arrives 2 cycles later.
      imem_ack = 1'b0;
      set_id(1'b1, 2'b10, 1'b0, 32'h3040, 16'h0, 26'h0, 32'h0000_4000);
      #3 chk("jr_flush", {31'h0, flush_ifid}, 32'h1);
      tick();
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      #3 chk("drop_req_a", {31'h0, imem_req}, 32'h0);
      tick();
      imem_ack = 1'b1;
      #3 chk("drop_req_b", {31'h0, imem_req}, 32'h0);
      tick();
      exp_fetch.push_back(32'h4000); exp_fetch.push_back(32'h4004);
      exp_fetch.push_back(32'h4008);
      exp_if.push_back(32'h4000); exp_if.push_back(32'h4004); exp_if.push_back(32'h4008);
      #3 chk("jr_target", imem_addr, 32'h4000);
      tick();

      // bne not taken, then taken branch with id_valid low: both sequential.
      set_id(1'b1, 2'b01, 1'b0, 32'h4000, 16'h0010, 26'h0, 32'h0);
      #3 chk("bne_nt_flush", {31'h0, flush_ifid}, 32'h0);
      tick();
      set_id(1'b0, 2'b01, 1'b1, 32'h4004, 16'h0010, 26'h0, 32'h0);
      #3 chk("bubble_br_flush", {31'h0, flush_ifid}, 32'h0);
      tick();
      imem_ack = 1'b0;
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();

      // jr to a misaligned top address: low bits cleared, then pc wraps to 0.
      set_id(1'b1, 2'b10, 1'b0, 32'h4004, 16'h0, 26'h0, 32'hFFFF_FFFE);
      #3 chk("jr2_flush", {31'h0, flush_ifid}, 32'h1);
      tick();
      set_id(1'b0, 2'b00, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      imem_ack = 1'b1;
      tick();
      exp_fetch.push_back(32'hFFFF_FFFC); exp_fetch.push_back(32'h0);
      exp_if.push_back(32'hFFFF_FFFC); exp_if.push_back(32'h0);
      #3 chk("jr_align", imem_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      imem_ack = 1'b0;
      tick();

      // Reset with a request outstanding, then resume from RESET_PC.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_ack = 1'b1;
      exp_fetch.push_back(32'h3000);
      exp_if.push_back(32'h3000);
      #3 chk("rerst_addr", imem_addr, 32'h3000);
      tick();
      imem_ack = 1'b0;
      tick();
      tick();

      chk("fetch_q_empty", exp_fetch.size(), 32'h0);
      chk("if_q_empty", exp_if.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
